// File: rtl/dekodier_pkg.sv
// Shared decode definitions: opcode/format constants and the decoded bundle.
// Used by befehl_dekoder and dekodier_stufe (optional flush: DEKODIER_FLUSH_EN).
package dekodier_pkg;

    localparam logic [5:0] OP_LHI    = 6'b110000;
    localparam logic [5:0] OP_LOAD0  = 6'b111000;
    localparam logic [5:0] OP_LOAD1  = 6'b111001;
    localparam logic [5:0] OP_STORE0 = 6'b111010;
    localparam logic [5:0] OP_STORE1 = 6'b111011;
    localparam logic [5:0] OP_JABS   = 6'b111100;
    localparam logic [5:0] OP_BCOND  = 6'b111101;
    localparam logic [5:0] OP_BNCOND = 6'b111110;
    localparam logic [5:0] OP_JAL    = 6'b111111;
    localparam logic [5:0] OP_JREL   = 6'b010000;

    localparam logic [1:0] FMT_REG  = 2'b00;
    localparam logic [1:0] FMT_JMP  = 2'b01;
    localparam logic [1:0] KAT_FP   = 2'b10;

    typedef struct packed {
        logic [5:0]  quell1;
        logic [5:0]  quell2;
        logic [5:0]  ziel;
        logic [31:0] idaten;
        logic        imm_aktiv;
        logic [5:0]  fkt_code;
        logic        jal;
        logic        relativ;
        logic        absolut;
        logic        load;
        logic        store;
        logic        unbedingt;
        logic        bedingt;
        logic        sprung_bed;
    } bundle_t;

endpackage

// File: rtl/befehl_dekoder.sv
// Purely combinational decode of one 32-bit instruction word into bundle_t.
module befehl_dekoder
    import dekodier_pkg::*;
(
    input  logic [31:0] instruktion,
    output bundle_t     bundle
);

    logic [5:0] op;
    logic [1:0] fmt;
    logic [4:0] z, q1, q2;
    logic [5:0] fkt;
    logic       fp;

    assign op  = instruktion[31:26];
    assign fmt = instruktion[31:30];
    assign z   = instruktion[25:21];
    assign q1  = instruktion[20:16];
    assign q2  = instruktion[15:11];
    assign fkt = instruktion[5:0];
    assign fp  = (fmt == FMT_REG) && (fkt[5:4] == KAT_FP);

    always_comb begin
        bundle = '0;

        bundle.quell1 = {fp, q1};
        if (op == OP_STORE0)      bundle.quell2 = {1'b0, z};
        else if (op == OP_STORE1) bundle.quell2 = {1'b1, z};
        else                      bundle.quell2 = {fp, q2};

        if (op == OP_LOAD1 || op == OP_STORE1 || (fp && fkt[3:0] < 4'd8))
            bundle.ziel = {1'b1, z};
        else if (fmt == FMT_REG || fmt[1])
            bundle.ziel = {1'b0, z};

        if (fmt == FMT_JMP)
            bundle.idaten = {6'b0, instruktion[25:0]};
        else if (op == OP_LHI)
            bundle.idaten = {instruktion[15:0], 16'b0};
        else if (fmt[1] && op > OP_LHI && op < OP_LOAD0)
            bundle.idaten = {16'b0, instruktion[15:0]};
        else if (fmt[1])
            bundle.idaten = {{16{instruktion[15]}}, instruktion[15:0]};
        bundle.imm_aktiv = (fmt == FMT_JMP) || fmt[1];

        if (fmt == FMT_REG)
            bundle.fkt_code = fkt;
        else if (!(op == OP_LHI || fmt == FMT_JMP || op >= OP_LOAD0))
            bundle.fkt_code = {1'b0, op[4:0]};

        bundle.jal        = (op == OP_JAL);
        bundle.relativ    = (op == OP_JAL) || (op == OP_JREL) || (op == OP_BCOND) || (op == OP_BNCOND);
        bundle.absolut    = (op == OP_JABS);
        bundle.load       = (op == OP_LOAD0) || (op == OP_LOAD1);
        bundle.store      = (op == OP_STORE0) || (op == OP_STORE1);
        bundle.unbedingt  = (op == OP_JABS) || (op == OP_JAL) || (op == OP_JREL);
        bundle.bedingt    = (op == OP_BCOND) || (op == OP_BNCOND);
        bundle.sprung_bed = (op == OP_BCOND);
    end

endmodule

// File: rtl/dekodier_stufe.sv
// Buffered decode stage: TIEFE-entry instruction FIFO feeding a registered decode bundle.
// Optional synchronous Flush port enabled by DEKODIER_FLUSH_EN.
module dekodier_stufe
    import dekodier_pkg::*;
#(
    parameter  int TIEFE = 4,
    localparam int ZB    = $clog2(TIEFE) + 1
) (
    input  logic          Takt,
    input  logic          Reset,
`ifdef DEKODIER_FLUSH_EN
    input  logic          Flush,
`endif
    input  logic          EinGueltig,
    output logic          EinBereit,
    input  logic [31:0]   Instruktion,
    output logic          AusGueltig,
    input  logic          AusBereit,
    output logic [5:0]    QuellRegister1,
    output logic [5:0]    QuellRegister2,
    output logic [5:0]    ZielRegister,
    output logic [31:0]   IDaten,
    output logic          ImmediateAktiv,
    output logic [5:0]    FunktionsCode,
    output logic          JALBefehl,
    output logic          RelativerSprung,
    output logic          AbsoluterSprung,
    output logic          LoadBefehl,
    output logic          StoreBefehl,
    output logic          UnbedingterSprungBefehl,
    output logic          BedingterSprungBefehl,
    output logic          Sprungbedingung,
    output logic [ZB-1:0] Fuellstand
);

    localparam int AW = $clog2(TIEFE);

    logic [31:0]   mem_q [TIEFE];
    logic [31:0]   mem_d [TIEFE];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [ZB-1:0] fuell_q, fuell_d;
    logic          aus_gueltig_q, aus_gueltig_d;
    bundle_t       bundle_q, bundle_d, kopf;
    logic          voll, leer, push, pop;

    assign voll      = (fuell_q == ZB'(TIEFE));
    assign leer      = (fuell_q == '0);
    assign EinBereit = !voll && !Reset;
    assign push      = EinGueltig && EinBereit;
    assign pop       = !leer && (!aus_gueltig_q || AusBereit);

    befehl_dekoder u_dekoder (
        .instruktion (mem_q[rd_q]),
        .bundle      (kopf)
    );

    always_comb begin
        mem_d         = mem_q;
        wr_d          = wr_q;
        rd_d          = rd_q;
        fuell_d       = fuell_q;
        aus_gueltig_d = aus_gueltig_q;
        bundle_d      = bundle_q;

        if (push) begin
            mem_d[wr_q] = Instruktion;
            wr_d        = wr_q + AW'(1);
        end
        // Without a pop, AusBereit can only be high here when the FIFO is empty.
        if (pop) begin
            bundle_d      = kopf;
            rd_d          = rd_q + AW'(1);
            aus_gueltig_d = 1'b1;
        end else if (AusBereit) begin
            aus_gueltig_d = 1'b0;
        end
        fuell_d = fuell_q + ZB'(push) - ZB'(pop);

`ifdef DEKODIER_FLUSH_EN
        if (Flush) begin
            mem_d         = mem_q;
            wr_d          = '0;
            rd_d          = '0;
            fuell_d       = '0;
            aus_gueltig_d = 1'b0;
            bundle_d      = bundle_q;
        end
`endif
    end

    always_ff @(posedge Takt or posedge Reset) begin
        if (Reset) begin
            mem_q         <= '{default: '0};
            wr_q          <= '0;
            rd_q          <= '0;
            fuell_q       <= '0;
            aus_gueltig_q <= 1'b0;
            bundle_q      <= '0;
        end else begin
            mem_q         <= mem_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            fuell_q       <= fuell_d;
            aus_gueltig_q <= aus_gueltig_d;
            bundle_q      <= bundle_d;
        end
    end

    assign AusGueltig              = aus_gueltig_q;
    assign Fuellstand              = fuell_q;
    assign QuellRegister1          = bundle_q.quell1;
    assign QuellRegister2          = bundle_q.quell2;
    assign ZielRegister            = bundle_q.ziel;
    assign IDaten                  = bundle_q.idaten;
    assign ImmediateAktiv          = bundle_q.imm_aktiv;
    assign FunktionsCode           = bundle_q.fkt_code;
    assign JALBefehl               = bundle_q.jal;
    assign RelativerSprung         = bundle_q.relativ;
    assign AbsoluterSprung         = bundle_q.absolut;
    assign LoadBefehl              = bundle_q.load;
    assign StoreBefehl             = bundle_q.store;
    assign UnbedingterSprungBefehl = bundle_q.unbedingt;
    assign BedingterSprungBefehl   = bundle_q.bedingt;
    assign Sprungbedingung         = bundle_q.sprung_bed;

endmodule

// File: tb/tb_dekodier_stufe.sv
// Directed bench for dekodier_stufe: decode vectors, back-pressure, reset (and flush with DEKODIER_FLUSH_EN).
module tb_dekodier_stufe;

    logic        Takt = 1'b0;
    logic        Reset = 1'b1;
    logic        Flush = 1'b0;
    logic        EinGueltig = 1'b0;
    logic        EinBereit;
    logic [31:0] Instruktion = '0;
    logic        AusGueltig;
    logic        AusBereit = 1'b0;
    logic [5:0]  QuellRegister1, QuellRegister2, ZielRegister, FunktionsCode;
    logic [31:0] IDaten;
    logic        ImmediateAktiv;
    logic        JALBefehl, RelativerSprung, AbsoluterSprung, LoadBefehl, StoreBefehl;
    logic        UnbedingterSprungBefehl, BedingterSprungBefehl, Sprungbedingung;
    logic [2:0]  Fuellstand;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned fails = 0;
    int unsigned acc;

    dekodier_stufe #(.TIEFE(4)) dut (
        .Takt                    (Takt),
        .Reset                   (Reset),
`ifdef DEKODIER_FLUSH_EN
        .Flush                   (Flush),
`endif
        .EinGueltig              (EinGueltig),
        .EinBereit               (EinBereit),
        .Instruktion             (Instruktion),
        .AusGueltig              (AusGueltig),
        .AusBereit               (AusBereit),
        .QuellRegister1          (QuellRegister1),
        .QuellRegister2          (QuellRegister2),
        .ZielRegister            (ZielRegister),
        .IDaten                  (IDaten),
        .ImmediateAktiv          (ImmediateAktiv),
        .FunktionsCode           (FunktionsCode),
        .JALBefehl               (JALBefehl),
        .RelativerSprung         (RelativerSprung),
        .AbsoluterSprung         (AbsoluterSprung),
        .LoadBefehl              (LoadBefehl),
        .StoreBefehl             (StoreBefehl),
        .UnbedingterSprungBefehl (UnbedingterSprungBefehl),
        .BedingterSprungBefehl   (BedingterSprungBefehl),
        .Sprungbedingung         (Sprungbedingung),
        .Fuellstand              (Fuellstand)
    );

    always #5 Takt = ~Takt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Push one word with AusBereit high, check no-bypass latency, then the decoded bundle.
    task automatic decode_case(input string name, input logic [31:0] w,
                               input logic [5:0] q1, input logic [5:0] q2, input logic [5:0] zr,
                               input logic [31:0] id, input logic imm, input logic [5:0] fc,
                               input logic [7:0] flags);
        @(negedge Takt);
        EinGueltig = 1'b1;
        Instruktion = w;
        AusBereit = 1'b1;
        @(negedge Takt);
        EinGueltig = 1'b0;
        chk({name, ".lat_gueltig"}, 32'(AusGueltig), 32'd0);
        chk({name, ".lat_fuell"}, 32'(Fuellstand), 32'd1);
        @(negedge Takt);
        chk({name, ".gueltig"}, 32'(AusGueltig), 32'd1);
        chk({name, ".q1"}, 32'(QuellRegister1), 32'(q1));
        chk({name, ".q2"}, 32'(QuellRegister2), 32'(q2));
        chk({name, ".ziel"}, 32'(ZielRegister), 32'(zr));
        chk({name, ".idaten"}, IDaten, id);
        chk({name, ".imm"}, 32'(ImmediateAktiv), 32'(imm));
        chk({name, ".fc"}, 32'(FunktionsCode), 32'(fc));
        chk({name, ".flags"},
            32'({JALBefehl, RelativerSprung, AbsoluterSprung, LoadBefehl, StoreBefehl,
                 UnbedingterSprungBefehl, BedingterSprungBefehl, Sprungbedingung}),
            32'(flags));
    endtask

    task automatic leeren(input string name);
        @(negedge Takt);
        EinGueltig = 1'b0;
        AusBereit = 1'b1;
        @(negedge Takt);
        chk({name, ".leer_gueltig"}, 32'(AusGueltig), 32'd0);
    endtask

    task automatic fill_with_ausbereit_low(input logic [31:0] basis, input int unsigned n);
        AusBereit = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge Takt);
            EinGueltig = 1'b1;
            Instruktion = basis + i;
        end
        @(negedge Takt);
        EinGueltig = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge Takt);
        @(negedge Takt);
        chk("rst.gueltig", 32'(AusGueltig), 32'd0);
        chk("rst.fuell", 32'(Fuellstand), 32'd0);
        chk("rst.einbereit", 32'(EinBereit), 32'd0);
        chk("rst.idaten", IDaten, 32'd0);
        chk("rst.ziel", 32'(ZielRegister), 32'd0);
        Reset = 1'b0;
        @(negedge Takt);
        chk("rst.einbereit_frei", 32'(EinBereit), 32'd1);

        // Decode vectors
        decode_case("sext", 32'h8420FFFF, 6'b000000, 6'b011111, 6'b000001,
                    32'hFFFFFFFF, 1'b1, 6'b000001, 8'h00);
        decode_case("lhi", 32'hC0201234, 6'b000000, 6'b000010, 6'b000001,
                    32'h12340000, 1'b1, 6'b000000, 8'h00);
        decode_case("store", 32'hEC430000, 6'b000011, 6'b100010, 6'b100010,
                    32'h00000000, 1'b1, 6'b000000, 8'h08);
        decode_case("jrel", 32'h40000010, 6'b000000, 6'b000000, 6'b000000,
                    32'h00000010, 1'b1, 6'b000000, 8'h44);
        decode_case("fp", 32'h00A41821, 6'b100100, 6'b100011, 6'b100101,
                    32'h00000000, 1'b0, 6'b100001, 8'h00);

        // Back-pressure: 6 pushes into TIEFE=4 with AusBereit low
        leeren("voll");
        AusBereit = 1'b0;
        acc = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge Takt);
            if (EinBereit) acc++;
            EinGueltig = 1'b1;
            Instruktion = 32'h84000000 + i;
        end
        @(negedge Takt);
        EinGueltig = 1'b0;
        chk("voll.angenommen", acc, 32'd5);
        chk("voll.fuell", 32'(Fuellstand), 32'd4);
        chk("voll.einbereit", 32'(EinBereit), 32'd0);
        chk("voll.gueltig", 32'(AusGueltig), 32'd1);
        chk("voll.kopf", IDaten, 32'd0);
        @(negedge Takt);
        chk("voll.stabil", IDaten, 32'd0);
        chk("voll.stabil_fuell", 32'(Fuellstand), 32'd4);
        AusBereit = 1'b1;
        chk("voll.einbereit_pop", 32'(EinBereit), 32'd0);
        for (int unsigned k = 1; k < 5; k++) begin
            @(negedge Takt);
            chk("drain.gueltig", 32'(AusGueltig), 32'd1);
            chk("drain.reihenfolge", IDaten, k);
            chk("drain.fuell", 32'(Fuellstand), 32'(4 - k));
        end
        @(negedge Takt);
        chk("drain.ende", 32'(AusGueltig), 32'd0);

        // Asynchronous reset with three queued entries
        leeren("reset");
        fill_with_ausbereit_low(32'h84000010, 4);
        chk("reset.fuell_vor", 32'(Fuellstand), 32'd3);
        chk("reset.gueltig_vor", 32'(AusGueltig), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("reset.gueltig", 32'(AusGueltig), 32'd0);
        chk("reset.fuell", 32'(Fuellstand), 32'd0);
        chk("reset.einbereit", 32'(EinBereit), 32'd0);
        chk("reset.idaten", IDaten, 32'd0);
        @(negedge Takt);
        Reset = 1'b0;
        decode_case("nach_reset", 32'hC0201234, 6'b000000, 6'b000010, 6'b000001,
                    32'h12340000, 1'b1, 6'b000000, 8'h00);

`ifdef DEKODIER_FLUSH_EN
        // Flush with concurrent push; decoded fields hold
        leeren("flush");
        fill_with_ausbereit_low(32'h84000020, 4);
        chk("flush.fuell_vor", 32'(Fuellstand), 32'd3);
        Flush = 1'b1;
        EinGueltig = 1'b1;
        Instruktion = 32'h84000077;
        @(negedge Takt);
        Flush = 1'b0;
        EinGueltig = 1'b0;
        chk("flush.gueltig", 32'(AusGueltig), 32'd0);
        chk("flush.fuell", 32'(Fuellstand), 32'd0);
        chk("flush.halten", IDaten, 32'h00000020);
        decode_case("nach_flush", 32'h40000010, 6'b000000, 6'b000000, 6'b000000,
                    32'h00000010, 1'b1, 6'b000000, 8'h44);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dekodier_stufe.md
# dekodier_stufe

Buffered, parametrised instruction-decode stage between fetch and execute. Accepts 32-bit instruction words over a valid/ready handshake and queues them in a `TIEFE`-entry FIFO. Decodes the FIFO head into a registered operand/control bundle, presented to execute with its own valid/ready handshake. Decode semantics match the existing single-register decoder; this stage adds queueing, back-pressure, fill reporting and optional flush.

## Interface
Parameters:
- `TIEFE`, 4: FIFO depth; power of two, at least 2.
- `ZB`, `$clog2(TIEFE)+1`: fill-counter width (derived, not overridable).

Ports:
- `Takt`  in  1  rising-edge clock
- `Reset`  in  1  reset, asynchronous, active-high
- `Flush`  in  1  synchronous pipeline flush (only with `DEKODIER_FLUSH_EN`)
- `EinGueltig`  in  1  instruction valid from fetch
- `EinBereit`  out  1  stage can accept
- `Instruktion`  in  32  instruction word
- `AusGueltig`  out  1  decoded bundle valid
- `AusBereit`  in  1  execute consumes bundle
- `QuellRegister1`, `QuellRegister2`, `ZielRegister`  out  6 each  {bank bit, index}
- `IDaten`  out  32  immediate
- `ImmediateAktiv`  out  1  immediate is active
- `FunktionsCode`  out  6  function code
- `JALBefehl`, `RelativerSprung`, `AbsoluterSprung`, `LoadBefehl`, `StoreBefehl`, `UnbedingterSprungBefehl`, `BedingterSprungBefehl`, `Sprungbedingung`  out  1 each  control flags
- `Fuellstand`  out  ZB  FIFO occupancy (excludes output register)

## Operation
Field definitions:
- Op=[31:26], Fmt=[31:30], Kat=[5:4], Z=[25:21], Q1=[20:16], Q2=[15:11], Fkt=[5:0], I16=[15:0], I26=[25:0].
- FP = (Fmt==00 && Kat==10).

Decode rules:
- Register fields:
  - QuellRegister1 = {FP,Q1}.
  - QuellRegister2 = {0,Z} for Op 111010; {1,Z} for Op 111011; else {FP,Q2}.
  - ZielRegister = {1,Z} if Op is 111001 or 111011, or if (FP && Fkt[3:0]<8). Otherwise {0,Z} if Fmt==00 or Fmt[1]==1. Otherwise 0.
- Immediate:
  - IDaten, in priority order:
    - Fmt==01: zero-extended I26.
    - Op==110000: {I16,16'b0}.
    - Fmt[1] && 110000<Op<111000: zero-extended I16.
    - Fmt[1]: sign-extended I16.
    - Otherwise: 0.
  - ImmediateAktiv = (Fmt==01 || Fmt[1]).
- Function code: FunktionsCode = Fkt if Fmt==00; 0 if Op==110000, Fmt==01 or Op≥111000; else {0,Op[4:0]}.
- Control flags:
  - JAL=111111.
  - Relativ ∈ {111111, 010000, 111101, 111110}.
  - Absolut=111100.
  - Load ∈ {111000, 111001}.
  - Store ∈ {111010, 111011}.
  - Unbedingt ∈ {111100, 111111, 010000}.
  - Bedingt ∈ {111101, 111110}.
  - Sprungbedingung=111101.

Datapath:
- Push when EinGueltig && EinBereit. EinBereit = !voll && !Reset, with no combinational dependence on AusBereit.
- Output-register load condition: FIFO non-empty && (!AusGueltig || AusBereit). On load, the decoded head is registered, the entry popped and AusGueltig set.
- AusGueltig clears when AusBereit && FIFO empty.
- Push and pop in the same cycle: Fuellstand unchanged. Pointers wrap modulo TIEFE.
- Strict FIFO order; no drops, no duplicates.

## Timing
- Reset: all outputs 0 (AusGueltig=0, Fuellstand=0, all decoded fields 0); pointers 0; EinBereit=0 while Reset is high.
- Latency: instruction accepted at edge N is valid on outputs after edge N+1 (minimum 2 edges, no bypass).
- Throughput: 1 instruction/cycle sustained when AusBereit is held high.
- Full FIFO: EinBereit=0 even if a pop occurs that cycle.
- Reset mid-operation: contents discarded immediately, asynchronously.
- Decoded outputs are stable while AusGueltig && !AusBereit.

## Configuration
- `DEKODIER_FLUSH_EN` defined:
  - `Flush` port present; highest priority after Reset.
  - Next edge: Fuellstand=0, AusGueltig=0, pointers reset.
  - A push in the same cycle is discarded.
  - Decoded fields hold their last value.
- Undefined: no `Flush` port; contents leave only via the output handshake.

## Structure
- Shared package `dekodier_pkg`: opcode constants, format/category constants, bundle struct type.
- Sub-module `befehl_dekoder`: purely combinational decode of one word into the bundle; the stage instantiates it on the FIFO head.

## Test plan
- Push 0x8420FFFF -> two edges later AusGueltig=1, IDaten=0xFFFFFFFF, ZielRegister=000001, FunktionsCode=000001, ImmediateAktiv=1.
- Push 0xC0201234 -> IDaten=0x12340000, FunktionsCode=0, ZielRegister=000001.
- Push 0xEC430000 -> QuellRegister1=000011, QuellRegister2=100010, ZielRegister=100010, StoreBefehl=1.
- Push 0x40000010 -> IDaten=0x10, RelativerSprung=1, UnbedingterSprungBefehl=1, ZielRegister=0.
- TIEFE=4, AusBereit=0, push 6 words -> 5 accepted, Fuellstand=4, EinBereit=0; then AusBereit=1 -> 5 words drain in order, one per cycle.
- Reset pulse with Fuellstand=3 (and Flush pulse when `DEKODIER_FLUSH_EN` is defined) -> AusGueltig=0 and Fuellstand=0 immediately; the next push appears after 2 edges.
